// File: rtl/execute_stage_mc.sv
// Execute stage with a combinational ALU, a branch unit and an optional iterative
// shift-add multiplier; results go to the memory stage through the EX/ME register.
module execute_stage_mc #(
    parameter int XLEN   = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk_ex,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] pc_ex,
    input  logic [XLEN-1:0] rs1_ex,
    input  logic [XLEN-1:0] rs2_ex,
    input  logic [XLEN-1:0] imm_ext_ex,
    input  logic            alu_a_src_ex,
    input  logic            alu_b_src_ex,
    input  logic [3:0]      alu_op_ex,
    input  logic [4:0]      bu_op_ex,
    input  logic [4:0]      rd_ex,
    input  logic [2:0]      dm_ctrl_ex,
    input  logic [1:0]      RU_DM_write_src_ex,
    input  logic            RUwrite_ex,
    input  logic            dm_wr_ex,
    input  logic [XLEN-1:0] pc_next_ex,
    input  logic            flush,
    input  logic            me_stall,
    output logic [XLEN-1:0] ALU_res_me,
    output logic [XLEN-1:0] RU_rs2_me,
    output logic [XLEN-1:0] pc_next_me,
    output logic [4:0]      rd_me,
    output logic [2:0]      dm_ctrl_me,
    output logic [1:0]      RU_DM_write_src_me,
    output logic            RUwrite_me,
    output logic            dm_wr_me,
    output logic            valid_me,
    output logic            next_pc_src_fe,
    output logic [XLEN-1:0] branch_target_fe,
    output logic            clr_de
);
    localparam int SHW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_next;

    logic [XLEN-1:0] op_a, op_b, alu_res;
    logic [SHW-1:0]  shamt;
    logic            cond, taken, is_mul, accept, redirect;
    logic            load_alu, load_mul, mul_start, mul_step;

    logic [SHW-1:0]  count;
    logic [XLEN-1:0] mcand, mplier, prod, mul_rs2, mul_pcn;
    logic [4:0]      mul_rd;
    logic [2:0]      mul_dmc;
    logic [1:0]      mul_src;
    logic            mul_ruw, mul_dmw;

    assign op_a  = alu_a_src_ex ? pc_ex : rs1_ex;
    assign op_b  = alu_b_src_ex ? imm_ext_ex : rs2_ex;
    assign shamt = op_b[SHW-1:0];

    // With the multiplier present, MUL never loads the ALU path, so its ALU value is unused.
    always_comb begin
        alu_res = '0;
        case (alu_op_ex)
            4'b0000: alu_res = op_a + op_b;
            4'b1000: alu_res = op_a - op_b;
            4'b0001: alu_res = op_a << shamt;
            4'b0010: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            4'b0011: alu_res = {{(XLEN-1){1'b0}}, op_a < op_b};
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = op_a >> shamt;
            4'b1101: alu_res = $unsigned($signed(op_a) >>> shamt);
            4'b0110: alu_res = op_a | op_b;
            4'b0111: alu_res = op_a & op_b;
            4'b1010: alu_res = op_b;
            4'b1001: alu_res = MUL_EN ? '0 : op_a + op_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (bu_op_ex[2:0])
            3'b000:  cond = (rs1_ex == rs2_ex);
            3'b001:  cond = (rs1_ex != rs2_ex);
            3'b100:  cond = ($signed(rs1_ex) <  $signed(rs2_ex));
            3'b101:  cond = ($signed(rs1_ex) >= $signed(rs2_ex));
            3'b110:  cond = (rs1_ex <  rs2_ex);
            3'b111:  cond = (rs1_ex >= rs2_ex);
            default: cond = 1'b0;
        endcase
        taken = bu_op_ex[4] | (bu_op_ex[3] & cond);
    end

    assign is_mul           = MUL_EN && (alu_op_ex == 4'b1001);
    assign in_ready         = (state == IDLE) && !me_stall && !flush;
    assign accept           = in_valid && in_ready;
    assign redirect         = accept && taken;
    assign next_pc_src_fe   = redirect;
    assign clr_de           = redirect;
    assign branch_target_fe = {alu_res[XLEN-1:1], 1'b0};

    always_ff @(posedge clk_ex or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Flush wins over a stall, so an in-flight multiply is dropped even while ME is blocked.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mul) state_next = BUSY;
            BUSY: if (flush) state_next = IDLE;
                  else if (count == SHW'(XLEN-1)) state_next = DONE;
            DONE: if (flush || !me_stall) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state)
            IDLE: begin
                load_alu  = accept && !is_mul;
                mul_start = accept && is_mul;
            end
            BUSY:    mul_step = !flush;
            DONE:    load_mul = !flush && !me_stall;
            default: ;
        endcase
    end

    always_ff @(posedge clk_ex or posedge rst) begin
        if (rst) begin
            count   <= '0;
            mcand   <= '0;
            mplier  <= '0;
            prod    <= '0;
            mul_rs2 <= '0;
            mul_pcn <= '0;
            mul_rd  <= '0;
            mul_dmc <= '0;
            mul_src <= '0;
            mul_ruw <= 1'b0;
            mul_dmw <= 1'b0;
        end else if (mul_start) begin
            count   <= '0;
            mcand   <= op_a;
            mplier  <= op_b;
            prod    <= '0;
            mul_rs2 <= rs2_ex;
            mul_pcn <= pc_next_ex;
            mul_rd  <= rd_ex;
            mul_dmc <= dm_ctrl_ex;
            mul_src <= RU_DM_write_src_ex;
            mul_ruw <= RUwrite_ex;
            mul_dmw <= dm_wr_ex && !taken;
        end else if (mul_step) begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

    // A stalled ME keeps everything; an unloaded edge only kills the control bits.
    always_ff @(posedge clk_ex or posedge rst) begin
        if (rst) begin
            ALU_res_me         <= '0;
            RU_rs2_me          <= '0;
            pc_next_me         <= '0;
            rd_me              <= '0;
            dm_ctrl_me         <= '0;
            RU_DM_write_src_me <= '0;
            RUwrite_me         <= 1'b0;
            dm_wr_me           <= 1'b0;
            valid_me           <= 1'b0;
        end else if (!me_stall) begin
            if (load_alu) begin
                ALU_res_me         <= alu_res;
                RU_rs2_me          <= rs2_ex;
                pc_next_me         <= pc_next_ex;
                rd_me              <= rd_ex;
                dm_ctrl_me         <= dm_ctrl_ex;
                RU_DM_write_src_me <= RU_DM_write_src_ex;
                RUwrite_me         <= RUwrite_ex;
                dm_wr_me           <= dm_wr_ex && !taken;
                valid_me           <= 1'b1;
            end else if (load_mul) begin
                ALU_res_me         <= prod;
                RU_rs2_me          <= mul_rs2;
                pc_next_me         <= mul_pcn;
                rd_me              <= mul_rd;
                dm_ctrl_me         <= mul_dmc;
                RU_DM_write_src_me <= mul_src;
                RUwrite_me         <= mul_ruw;
                dm_wr_me           <= mul_dmw;
                valid_me           <= 1'b1;
            end else begin
                RUwrite_me <= 1'b0;
                dm_wr_me   <= 1'b0;
                valid_me   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage_mc.sv
// Self-checking bench for execute_stage_mc: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_execute_stage_mc;
    localparam int XLEN = 32;

    logic        clk_ex = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [31:0] pc_ex, rs1_ex, rs2_ex, imm_ext_ex, pc_next_ex;
    logic        alu_a_src_ex, alu_b_src_ex;
    logic [3:0]  alu_op_ex;
    logic [4:0]  bu_op_ex, rd_ex;
    logic [2:0]  dm_ctrl_ex;
    logic [1:0]  RU_DM_write_src_ex;
    logic        RUwrite_ex, dm_wr_ex, flush, me_stall;
    logic [31:0] ALU_res_me, RU_rs2_me, pc_next_me, branch_target_fe;
    logic [4:0]  rd_me;
    logic [2:0]  dm_ctrl_me;
    logic [1:0]  RU_DM_write_src_me;
    logic        RUwrite_me, dm_wr_me, valid_me, next_pc_src_fe, clr_de;

    execute_stage_mc #(.XLEN(XLEN), .MUL_EN(1'b1)) dut (
        .clk_ex(clk_ex), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .pc_ex(pc_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .imm_ext_ex(imm_ext_ex),
        .alu_a_src_ex(alu_a_src_ex), .alu_b_src_ex(alu_b_src_ex),
        .alu_op_ex(alu_op_ex), .bu_op_ex(bu_op_ex), .rd_ex(rd_ex), .dm_ctrl_ex(dm_ctrl_ex),
        .RU_DM_write_src_ex(RU_DM_write_src_ex), .RUwrite_ex(RUwrite_ex), .dm_wr_ex(dm_wr_ex),
        .pc_next_ex(pc_next_ex), .flush(flush), .me_stall(me_stall),
        .ALU_res_me(ALU_res_me), .RU_rs2_me(RU_rs2_me), .pc_next_me(pc_next_me),
        .rd_me(rd_me), .dm_ctrl_me(dm_ctrl_me), .RU_DM_write_src_me(RU_DM_write_src_me),
        .RUwrite_me(RUwrite_me), .dm_wr_me(dm_wr_me), .valid_me(valid_me),
        .next_pc_src_fe(next_pc_src_fe), .branch_target_fe(branch_target_fe), .clr_de(clr_de)
    );

    always #5 clk_ex = ~clk_ex;

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            4'd0:    return a + b;
            4'd8:    return a - b;
            4'd1:    return a << sh;
            4'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:    return (a < b) ? 32'd1 : 32'd0;
            4'd4:    return a ^ b;
            4'd5:    return a >> sh;
            4'd13:   return $signed(a) >>> sh;
            4'd6:    return a | b;
            4'd7:    return a & b;
            4'd10:   return b;
            4'd9:    return a * b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit refTaken(input logic [4:0] bop, input logic [31:0] x, input logic [31:0] y);
        if (bop[4]) return 1'b1;
        if (!bop[3]) return 1'b0;
        case (bop[2:0])
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd4:    return $signed(x) <  $signed(y);
            3'd5:    return $signed(x) >= $signed(y);
            3'd6:    return x <  y;
            3'd7:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    // Model: a pending multiply is a product plus a count of remaining BUSY edges.
    bit          m_pending;
    int          m_steps;
    logic [31:0] m_prod, m_rs2, m_pcn, ma, mb;
    logic [4:0]  m_rd;
    logic [2:0]  m_dmc;
    logic [1:0]  m_src;
    bit          m_ruw, m_dmw;
    logic [31:0] e_alu, e_rs2, e_pcn;
    logic [4:0]  e_rd;
    logic [2:0]  e_dmc;
    logic [1:0]  e_src;
    bit          e_ruw, e_dmw, e_valid;

    always @(posedge clk_ex or posedge rst) begin
        if (rst) begin
            m_pending = 0; m_steps = 0;
            e_alu = 0; e_rs2 = 0; e_pcn = 0; e_rd = 0; e_dmc = 0; e_src = 0;
            e_ruw = 0; e_dmw = 0; e_valid = 0;
        end else begin
            ma = alu_a_src_ex ? pc_ex : rs1_ex;
            mb = alu_b_src_ex ? imm_ext_ex : rs2_ex;
            if (flush) begin
                m_pending = 0;
                if (!me_stall) begin e_valid = 0; e_ruw = 0; e_dmw = 0; end
            end else if (me_stall) begin
                if (m_pending && m_steps > 0) m_steps--;
            end else if (m_pending) begin
                if (m_steps > 0) begin
                    m_steps--;
                    e_valid = 0; e_ruw = 0; e_dmw = 0;
                end else begin
                    e_alu = m_prod; e_rs2 = m_rs2; e_pcn = m_pcn; e_rd = m_rd;
                    e_dmc = m_dmc; e_src = m_src; e_ruw = m_ruw; e_dmw = m_dmw; e_valid = 1;
                    m_pending = 0;
                end
            end else if (in_valid) begin
                if (alu_op_ex == 4'd9) begin
                    m_prod = ma * mb; m_rs2 = rs2_ex; m_pcn = pc_next_ex; m_rd = rd_ex;
                    m_dmc = dm_ctrl_ex; m_src = RU_DM_write_src_ex; m_ruw = RUwrite_ex;
                    m_dmw = dm_wr_ex && !refTaken(bu_op_ex, rs1_ex, rs2_ex);
                    m_steps = XLEN; m_pending = 1;
                    e_valid = 0; e_ruw = 0; e_dmw = 0;
                end else begin
                    e_alu = refAlu(alu_op_ex, ma, mb); e_rs2 = rs2_ex; e_pcn = pc_next_ex;
                    e_rd = rd_ex; e_dmc = dm_ctrl_ex; e_src = RU_DM_write_src_ex; e_ruw = RUwrite_ex;
                    e_dmw = dm_wr_ex && !refTaken(bu_op_ex, rs1_ex, rs2_ex); e_valid = 1;
                end
            end else begin
                e_valid = 0; e_ruw = 0; e_dmw = 0;
            end
        end
    end

    task automatic checkOutput();
        logic [31:0] a, b;
        bit expReady, expRedir;
        a = alu_a_src_ex ? pc_ex : rs1_ex;
        b = alu_b_src_ex ? imm_ext_ex : rs2_ex;
        expReady = !m_pending && !me_stall && !flush;
        expRedir = in_valid && expReady && refTaken(bu_op_ex, rs1_ex, rs2_ex);
        compareValue("in_ready", 32'(in_ready), 32'(expReady));
        compareValue("next_pc_src_fe", 32'(next_pc_src_fe), 32'(expRedir));
        compareValue("clr_de", 32'(clr_de), 32'(expRedir));
        if (expRedir)
            compareValue("branch_target_fe", branch_target_fe, refAlu(alu_op_ex, a, b) & 32'hFFFF_FFFE);
        compareValue("valid_me", 32'(valid_me), 32'(e_valid));
        compareValue("RUwrite_me", 32'(RUwrite_me), 32'(e_ruw));
        compareValue("dm_wr_me", 32'(dm_wr_me), 32'(e_dmw));
        compareValue("ALU_res_me", ALU_res_me, e_alu);
        compareValue("RU_rs2_me", RU_rs2_me, e_rs2);
        compareValue("pc_next_me", pc_next_me, e_pcn);
        compareValue("rd_me", 32'(rd_me), 32'(e_rd));
        compareValue("dm_ctrl_me", 32'(dm_ctrl_me), 32'(e_dmc));
        compareValue("RU_DM_write_src_me", 32'(RU_DM_write_src_me), 32'(e_src));
    endtask

    always begin
        @(posedge clk_ex);
        #8;
        if (checking && !rst) checkOutput();
    end

    task automatic applyStimulus(input bit valid, input logic [3:0] op, input logic [4:0] bop,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] pc, input logic [31:0] imm,
                                 input bit asrc, input bit bsrc, input bit stall, input bit fl);
        in_valid = valid; alu_op_ex = op; bu_op_ex = bop;
        rs1_ex = rs1; rs2_ex = rs2; pc_ex = pc; imm_ext_ex = imm;
        alu_a_src_ex = asrc; alu_b_src_ex = bsrc; me_stall = stall; flush = fl;
        rd_ex = 5'($urandom_range(0, 31));
        dm_ctrl_ex = 3'($urandom_range(0, 7));
        RU_DM_write_src_ex = 2'($urandom_range(0, 3));
        RUwrite_ex = 1'($urandom_range(0, 1));
        dm_wr_ex = 1'($urandom_range(0, 1));
        pc_next_ex = $urandom;
    endtask

    task automatic idle();
        applyStimulus(0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic waitMul(output int busy);
        busy = 0;
        #5;
        while (!in_ready && busy < 100) begin
            busy++;
            @(posedge clk_ex);
            #7;
        end
    endtask

    function automatic logic [31:0] randOperand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40));
            2: begin
                case ($urandom_range(0, 3))
                    0:       return 32'h0000_0000;
                    1:       return 32'hFFFF_FFFF;
                    2:       return 32'h8000_0000;
                    default: return 32'h7FFF_FFFF;
                endcase
            end
            default: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        endcase
    endfunction

    logic [3:0] opList [14] = '{4'd0, 4'd8, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5,
                                4'd13, 4'd6, 4'd7, 4'd10, 4'd9, 4'd11, 4'd15};

    initial begin
        int busy;
        logic [3:0]  op;
        logic [4:0]  bop;
        logic [31:0] r1, r2;
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk_ex);
        #2 rst = 1'b0;
        checking = 1'b1;
        #5;
        compareValue("reset_valid_me", 32'(valid_me), 32'd0);
        compareValue("reset_alu_res", ALU_res_me, 32'd0);
        compareValue("reset_in_ready", 32'(in_ready), 32'd1);

        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd0, 5'd0, 32'd7, 32'hFFFF_FFFC, 32'h40, 0, 0, 0, 0, 0);
        #5 compareValue("add_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk_ex); #2; idle(); #5;
        compareValue("add_alu_res", ALU_res_me, 32'd3);
        compareValue("add_valid_me", 32'(valid_me), 32'd1);

        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd0, 5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1, 1, 0, 0);
        #5;
        compareValue("blt_next_pc_src", 32'(next_pc_src_fe), 32'd1);
        compareValue("blt_clr_de", 32'(clr_de), 32'd1);
        compareValue("blt_target", branch_target_fe, 32'h120);
        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd0, 5'b01110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1, 1, 0, 0);
        #5;
        compareValue("bltu_next_pc_src", 32'(next_pc_src_fe), 32'd0);
        compareValue("bltu_clr_de", 32'(clr_de), 32'd0);

        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd9, 5'd0, 32'h10001, 32'h10001, 0, 0, 0, 0, 0, 0);
        #5 compareValue("mul_accept", 32'(in_ready), 32'd1);
        @(posedge clk_ex); #2; idle();
        waitMul(busy);
        compareValue("mul_busy_cycles", 32'(busy), 32'd33);
        compareValue("mul_product", ALU_res_me, 32'h0002_0001);
        compareValue("mul_valid_me", 32'(valid_me), 32'd1);

        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd9, 5'd0, 32'hFFFF_FFFF, 32'd3, 0, 0, 0, 0, 0, 0);
        @(posedge clk_ex); #2; idle();
        repeat (32) @(posedge clk_ex);
        #2 applyStimulus(0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk_ex); #2;
            if (k == 2) idle();
            #5;
            compareValue("stall_hold_alu", ALU_res_me, 32'h0002_0001);
            compareValue("stall_hold_valid", 32'(valid_me), 32'd0);
        end
        @(posedge clk_ex); #7;
        compareValue("stall_mul_product", ALU_res_me, 32'hFFFF_FFFD);
        compareValue("stall_mul_valid", 32'(valid_me), 32'd1);

        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd9, 5'd0, 32'h12345, 32'h10, 0, 0, 0, 0, 0, 0);
        @(posedge clk_ex); #2; idle();
        repeat (9) @(posedge clk_ex);
        #2 applyStimulus(0, 4'd0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 1);
        #5 compareValue("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk_ex); #2; idle(); #5;
        compareValue("flush_idle_ready", 32'(in_ready), 32'd1);
        compareValue("flush_valid_me", 32'(valid_me), 32'd0);
        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd9, 5'd0, 32'h12345, 32'h10, 0, 0, 0, 0, 0, 0);
        @(posedge clk_ex); #2; idle();
        waitMul(busy);
        compareValue("flush_next_mul_cycles", 32'(busy), 32'd33);
        compareValue("flush_next_mul_product", ALU_res_me, 32'h0012_3450);

        @(posedge clk_ex); #2;
        applyStimulus(1, 4'd9, 5'd0, 32'hDEAD, 32'hBEEF, 0, 0, 0, 0, 0, 0);
        @(posedge clk_ex); #2; idle();
        repeat (4) @(posedge clk_ex);
        #2 rst = 1'b1;
        #1;
        compareValue("async_rst_alu", ALU_res_me, 32'd0);
        compareValue("async_rst_valid", 32'(valid_me), 32'd0);
        compareValue("async_rst_pc_next", pc_next_me, 32'd0);
        #2 rst = 1'b0;
        #2 compareValue("rst_release_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_ex); #2;
            op  = opList[$urandom_range(0, 13)];
            bop = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
            if (op == 4'd9) bop = 5'd0;
            r1 = randOperand();
            r2 = ($urandom_range(0, 5) == 0) ? r1 : randOperand();
            applyStimulus($urandom_range(0, 9) < 7, op, bop, r1, r2, $urandom, randOperand(),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
        end
        @(posedge clk_ex); #2; idle();
        repeat (3) @(posedge clk_ex);
        #9;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage_mc.md
EXECUTE_STAGE_MC -- requirements
Module: execute_stage_mc

Interface
REQ-001 Parameter XLEN, default 32, datapath width in bits (>=8, power of two).
REQ-002 Parameter MUL_EN, default 1, 1 = iterative MUL unit present; 0 = MUL op executes as ADD.
REQ-003 clk_ex  in  1  stage clock; all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  decode stage presents an instruction; in_ready  out  1  EX accepts it this cycle.
REQ-006 pc_ex, rs1_ex, rs2_ex, imm_ext_ex  in  XLEN each  PC, forwarded rs1/rs2, extended immediate.
REQ-007 alu_a_src_ex, alu_b_src_ex  in  1 each  select pc_ex / imm_ext_ex instead of rs1_ex / rs2_ex.
REQ-008 alu_op_ex  in  4, bu_op_ex  in  5, rd_ex  in  5, dm_ctrl_ex  in  3, RU_DM_write_src_ex  in  2, RUwrite_ex  in  1, dm_wr_ex  in  1, pc_next_ex  in  XLEN.
REQ-009 flush  in  1  squash the EX instruction; me_stall  in  1  memory stage cannot accept.
REQ-010 ALU_res_me, RU_rs2_me, pc_next_me  out  XLEN; rd_me 5, dm_ctrl_me 3, RU_DM_write_src_me 2, RUwrite_me 1, dm_wr_me 1, valid_me 1  registered EX/ME outputs.
REQ-011 next_pc_src_fe  out  1, branch_target_fe  out  XLEN, clr_de  out  1  combinational redirect.

Function
REQ-012 Operands: a = alu_a_src_ex ? pc_ex : rs1_ex; b = alu_b_src_ex ? imm_ext_ex : rs2_ex, combinational, no added register.
REQ-013 alu_op: 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND, 1010 pass b, 1001 MUL (low XLEN bits of a*b); others -> 0.
REQ-014 Shift amount = b[log2(XLEN)-1:0]; all arithmetic modulo 2^XLEN.
REQ-015 Branch compare on rs1_ex vs rs2_ex: bu_op[4]=jump (always taken), bu_op[3]=branch enable, bu_op[2:0] = 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes not taken.
REQ-016 next_pc_src_fe = clr_de = in_valid & in_ready & taken; branch_target_fe = ALU result with bit 0 cleared.
REQ-017 in_ready = (state==IDLE) & !me_stall & !flush.
REQ-018 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-019 IDLE, accept of non-MUL op: EX/ME register loads result and sideband, valid_me=1 on the same edge (latency 1).
REQ-020 IDLE, accept of MUL (MUL_EN=1): operands and sideband latched, counter=0, -> BUSY; no load of EX/ME that edge.
REQ-021 BUSY: one shift-add step per edge; after step with counter==XLEN-1 -> DONE.
REQ-022 DONE: first edge with !me_stall loads product and latched sideband, valid_me=1, -> IDLE; MUL latency XLEN+1 edges from accept.
REQ-023 me_stall=1: all EX/ME outputs hold; BUSY continues stepping; DONE holds.
REQ-024 Edge with no load and !me_stall: valid_me=0, RUwrite_me=0, dm_wr_me=0 (bubble); data outputs may hold.
REQ-025 flush=1: BUSY/DONE -> IDLE next edge, MUL result discarded; EX/ME receives a bubble unless me_stall=1.
REQ-026 Priority: rst > flush > me_stall > normal operation.
REQ-027 Taken branch/jump never writes dm; RUwrite_ex passes through (link write).

Reset
REQ-028 rst=1 asynchronously: state=IDLE, counter=0, all EX/ME outputs 0, valid_me=0.
REQ-029 Reset mid-MUL abandons the operation; first edge after release behaves as IDLE.

Verification
REQ-030 XLEN=32, ADD a=7 b=0xFFFFFFFC, accept -> next edge ALU_res_me=3, valid_me=1.
REQ-031 BLT rs1=-1 rs2=1, pc=0x100 imm=0x20 -> same cycle next_pc_src_fe=1, clr_de=1, branch_target_fe=0x120; BLTU same operands -> 0.
REQ-032 MUL 0x10001 x 0x10001 -> in_ready=0 for 33 cycles, ALU_res_me=0x00020001 after edge 33, valid_me=1.
REQ-033 MUL with me_stall asserted in DONE 3 cycles -> outputs held, load on first unstalled edge, product correct.
REQ-034 flush during BUSY cycle 10 -> IDLE next edge, valid_me=0, next MUL accepted gives correct product.
REQ-035 rst pulse during BUSY -> all outputs 0 immediately without clock edge, in_ready=1 after release.
